sim_run_ctrl: RTL and testbench
===============================

SIM_RUN_CTRL -- requirements
Module: sim_run_ctrl

Interface
Parameters:
REQ-001 The block SHALL have parameter RST_CYCLES, default 25: number of clk cycles cpu_rst stays high after rst deasserts.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 32: width of the run-cycle counter.
REQ-003 The block SHALL have parameter TIMEOUT, default 150000000: run-cycle limit; 0 disables the watchdog.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 16: output-byte FIFO depth, power of two and at least 2.
REQ-005 The block SHALL have parameter OUT_ADDR, default 32'h30000: console-byte store address.
REQ-006 The block SHALL have parameter HALT_ADDR, default 32'h30004: program-end store address.

Ports:
REQ-007 The block SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-008 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-009 The block SHALL have port mem_a, input, 32 bits: CPU memory-bus address (observed only).
REQ-010 The block SHALL have port mem_wr, input, 1 bit: CPU store strobe, one cycle per byte.
REQ-011 The block SHALL have port mem_dout, input, 8 bits: CPU store data byte.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer accepts the FIFO head byte.
REQ-013 The block SHALL have port cpu_rst, output, 1 bit: reset driven to the CPU core.
REQ-014 The block SHALL have port out_valid, output, 1 bit: FIFO non-empty.
REQ-015 The block SHALL have port out_data, output, 8 bits: FIFO head byte.
REQ-016 The block SHALL have port cycle_cnt, output, CNT_WIDTH bits: run cycles elapsed.
REQ-017 The block SHALL have port exit_code, output, 8 bits: data byte of the halt store.
REQ-018 The block SHALL have port overflow, output, 1 bit: sticky, a byte was dropped.
REQ-019 The block SHALL have port timed_out, output, 1 bit: the watchdog fired.
REQ-020 The block SHALL have port finished, output, 1 bit: run ended and FIFO drained.

Function
REQ-021 The block SHALL implement a state machine with states HOLD, RUN, DONE and TMO; rst forces HOLD.
REQ-022 In HOLD the block SHALL count cycles with rst low; after RST_CYCLES such cycles it SHALL enter RUN, and cpu_rst SHALL go low on the first RUN cycle.
REQ-023 cpu_rst SHALL be 1 in HOLD, DONE and TMO, and 0 in RUN.
REQ-024 In RUN, cycle_cnt SHALL increment every cycle and saturate at all-ones; it SHALL hold its value in DONE and TMO.
REQ-025 In RUN, mem_wr=1 with mem_a==HALT_ADDR SHALL load exit_code with mem_dout and enter DONE on the next cycle.
REQ-026 In RUN, mem_wr=1 with mem_a==OUT_ADDR SHALL push mem_dout into the FIFO; the byte becomes visible on out_data one cycle later.
REQ-027 Stores to any other address, and any store outside RUN, SHALL be ignored.
REQ-028 A push while the FIFO is full and no pop occurs in the same cycle SHALL drop the byte and set overflow, which stays set until rst.
REQ-029 A pop SHALL occur when out_valid && out_ready; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-030 A simultaneous push and pop SHALL keep the count unchanged, including when the FIFO is full; no overflow is flagged.
REQ-031 Read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit or a count.
REQ-032 With TIMEOUT != 0 and no halt store, when cycle_cnt reaches TIMEOUT-1 in RUN the block SHALL enter TMO on the next cycle and set timed_out.
REQ-033 If a halt store and the timeout condition occur in the same cycle, the halt store SHALL win: DONE is entered and timed_out stays 0.
REQ-034 DONE and TMO SHALL be terminal until rst, and the FIFO SHALL keep draining in both.
REQ-035 finished SHALL be 1 iff the state is DONE or TMO and the FIFO is empty; it SHALL be registered with no combinational path from out_ready.

Reset
REQ-036 On rst, all outputs SHALL reset to: cpu_rst=1, out_valid=0, out_data=0, cycle_cnt=0, exit_code=0, overflow=0, timed_out=0, finished=0.
REQ-037 On rst, the FIFO pointers SHALL clear and the HOLD counter SHALL reload.
REQ-038 rst asserted mid-RUN SHALL discard FIFO contents and restart the full RST_CYCLES hold.

Verification
REQ-039 Reset sequence: rst high 5 cycles then low, with RST_CYCLES=25 -> cpu_rst high exactly 25 cycles after rst falls; cycle_cnt=1 on the second RUN cycle.
REQ-040 Console output: stores 0x48, 0x69 to 0x30000 with out_ready=1 -> out_data shows 0x48 then 0x69, one cycle after each store.
REQ-041 Overflow and backpressure: with FIFO_DEPTH=4 and out_ready=0, 5 stores -> out_valid=1, overflow=1; 4 pops return the first 4 bytes in order.
REQ-042 Full FIFO with push+pop in the same cycle -> count stays 4, overflow stays 0, the new byte is last out.
REQ-043 Halt: store 0x07 to 0x30004 with 2 bytes queued -> cpu_rst=1 next cycle, exit_code=0x07, finished=1 only after both bytes are popped.
REQ-044 Watchdog: TIMEOUT=100 with no halt store -> timed_out=1 and cycle_cnt=100 frozen; a halt store on cycle 99 -> DONE, timed_out=0.

Source files
------------

// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: CPU run controller with reset hold, console byte FIFO, halt capture and watchdog
module sim_run_ctrl #(
  parameter int          RST_CYCLES = 25,
  parameter int          CNT_WIDTH  = 32,
  parameter int          TIMEOUT    = 150000000,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] OUT_ADDR   = 32'h30000,
  parameter logic [31:0] HALT_ADDR  = 32'h30004
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          mem_a,
  input  logic                 mem_wr,
  input  logic [7:0]           mem_dout,
  input  logic                 out_ready,
  output logic                 cpu_rst,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [7:0]           exit_code,
  output logic                 overflow,
  output logic                 timed_out,
  output logic                 finished
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(RST_CYCLES + 1);
  typedef enum logic [1:0] {HOLD, RUN, DONE, TMO} state_t;
  state_t               r_state, w_next;
  logic [HW-1:0]        r_hold;
  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [AW:0]          r_wr, r_rd, w_cnt, w_cnt_nx;
  logic [CNT_WIDTH-1:0] r_cyc;
  logic [7:0]           r_exit;
  logic                 r_ovf, r_fin;
  logic                 w_push, w_pop, w_full, w_empty, w_wen, w_halt, w_tmo;
  assign w_halt   = r_state == RUN && mem_wr && mem_a == HALT_ADDR;
  assign w_push   = r_state == RUN && mem_wr && mem_a == OUT_ADDR;
  assign w_tmo    = TIMEOUT != 0 && r_cyc == CNT_WIDTH'(TIMEOUT - 1);
  assign w_cnt    = r_wr - r_rd;
  assign w_empty  = w_cnt == '0;
  assign w_full   = w_cnt == (AW+1)'(FIFO_DEPTH);
  assign w_pop    = !w_empty && out_ready;
  assign w_wen    = w_push && (!w_full || w_pop);
  assign w_cnt_nx = w_cnt + (AW+1)'(w_wen) - (AW+1)'(w_pop);
  assign cpu_rst   = r_state != RUN;
  assign timed_out = r_state == TMO;
  assign out_valid = !w_empty;
  assign out_data  = w_empty ? 8'h00 : r_mem[r_rd[AW-1:0]];
  assign cycle_cnt = r_cyc;
  assign exit_code = r_exit;
  assign overflow  = r_ovf;
  assign finished  = r_fin;
  // state register; rst always restarts the hold phase
  always_ff @(posedge clk)
    r_state <= rst ? HOLD : w_next;
  // next state: hold countdown, then run until a halt store (wins) or watchdog expiry
  always_comb begin
    w_next = r_state;
    case (r_state)
      HOLD:    w_next = r_hold == HW'(RST_CYCLES - 1) ? RUN : HOLD;
      RUN:     w_next = w_halt ? DONE : w_tmo ? TMO : RUN;
      default: w_next = r_state;
    endcase
  end
  // counts rst-low cycles spent in HOLD
  always_ff @(posedge clk)
    r_hold <= (rst || r_state != HOLD) ? '0 : r_hold + 1'b1;
  // FIFO storage; a full FIFO still accepts when the head is popped this cycle
  always_ff @(posedge clk)
    if (w_wen) r_mem[r_wr[AW-1:0]] <= mem_dout;
  // FIFO pointers with an extra wrap bit to tell full from empty
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      r_wr <= r_wr + (AW+1)'(w_wen);
      r_rd <= r_rd + (AW+1)'(w_pop);
    end
  end
  // sticky drop flag
  always_ff @(posedge clk)
    if (rst) r_ovf <= 1'b0;
    else if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
  // captures the halt store data byte
  always_ff @(posedge clk)
    if (rst) r_exit <= '0;
    else if (w_halt) r_exit <= mem_dout;
  // saturating run-cycle counter, frozen outside RUN
  always_ff @(posedge clk)
    if (rst) r_cyc <= '0;
    else if (r_state == RUN && r_cyc != '1) r_cyc <= r_cyc + 1'b1;
  // finished is computed from next state and next count so it never depends on out_ready combinationally
  always_ff @(posedge clk)
    r_fin <= !rst && (w_next == DONE || w_next == TMO) && w_cnt_nx == '0;
endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl: scoreboard bench for sim_run_ctrl (RST_CYCLES=25, FIFO_DEPTH=4, TIMEOUT=100)
module tb_sim_run_ctrl;
  localparam logic [31:0] OUT  = 32'h30000;
  localparam logic [31:0] HALT = 32'h30004;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_a = '0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_dout = '0;
  logic        out_ready = 1'b0;
  logic        cpu_rst, out_valid, overflow, timed_out, finished;
  logic [7:0]  out_data, exit_code;
  logic [31:0] cycle_cnt;
  logic [7:0]  q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  sim_run_ctrl #(
    .RST_CYCLES(25), .CNT_WIDTH(32), .TIMEOUT(100), .FIFO_DEPTH(4),
    .OUT_ADDR(OUT), .HALT_ADDR(HALT)
  ) dut (
    .clk(clk), .rst(rst), .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout),
    .out_ready(out_ready), .cpu_rst(cpu_rst), .out_valid(out_valid), .out_data(out_data),
    .cycle_cnt(cycle_cnt), .exit_code(exit_code), .overflow(overflow),
    .timed_out(timed_out), .finished(finished)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic store(input logic [31:0] a, input logic [7:0] d, input bit expect_push);
    if (expect_push) q.push_back(d);
    mem_a = a;
    mem_dout = d;
    mem_wr = 1'b1;
    tick();
    mem_wr = 1'b0;
  endtask
  task automatic do_reset(input bit hold_store);
    int n;
    rst = 1'b1;
    mem_wr = 1'b0;
    out_ready = 1'b0;
    q.delete();
    repeat (5) tick();
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    chk("rst_exit_code", exit_code, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_timed_out", timed_out, 0);
    chk("rst_finished", finished, 0);
    rst = 1'b0;
    if (hold_store) begin
      mem_a = OUT;
      mem_dout = 8'hEE;
      mem_wr = 1'b1;
    end
    n = 0;
    while (cpu_rst && n < 100) begin
      n++;
      tick();
    end
    mem_wr = 1'b0;
    chk("hold_cycles", n, 25);
    chk("run_cycle_cnt0", cycle_cnt, 0);
    chk("run_out_valid0", out_valid, 0);
  endtask
  // scoreboard monitor: every byte presented must match the queue head; a pop retires it
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_byte got %0h expected none", out_data);
      end else begin
        chk("out_data", out_data, q[0]);
        if (out_ready) void'(q.pop_front());
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "bench timeout");
  end
  initial begin
    int n;
    // reset sequence, stores during HOLD ignored
    do_reset(1);
    tick();
    chk("cycle_cnt_second_run", cycle_cnt, 1);
    // console output
    out_ready = 1'b1;
    store(OUT, 8'h48, 1);
    chk("cons_valid_48", out_valid, 1);
    chk("cons_data_48", out_data, 8'h48);
    store(OUT, 8'h69, 1);
    chk("cons_data_69", out_data, 8'h69);
    store(32'h30008, 8'h55, 0);
    chk("other_addr_ignored", out_valid, 0);
    // overflow and backpressure
    do_reset(0);
    for (int i = 0; i < 4; i++) store(OUT, 8'hA0 + 8'(i), 1);
    chk("ovf_before", overflow, 0);
    store(OUT, 8'hA4, 0);
    chk("ovf_valid", out_valid, 1);
    chk("ovf_set", overflow, 1);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("ovf_drained", out_valid, 0);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_queue_empty", q.size(), 0);
    // full FIFO with simultaneous push and pop
    do_reset(0);
    for (int i = 0; i < 4; i++) store(OUT, 8'hB0 + 8'(i), 1);
    out_ready = 1'b1;
    store(OUT, 8'hB4, 1);
    chk("pp_overflow", overflow, 0);
    repeat (3) tick();
    chk("pp_one_left", out_valid, 1);
    tick();
    chk("pp_empty", out_valid, 0);
    chk("pp_queue_empty", q.size(), 0);
    // halt with two bytes queued
    do_reset(0);
    store(OUT, 8'hC1, 1);
    store(OUT, 8'hC2, 1);
    store(HALT, 8'h07, 0);
    chk("halt_cpu_rst", cpu_rst, 1);
    chk("halt_exit_code", exit_code, 8'h07);
    chk("halt_not_finished", finished, 0);
    chk("halt_timed_out", timed_out, 0);
    store(OUT, 8'hDD, 0);
    out_ready = 1'b1;
    tick();
    chk("halt_fin_one_left", finished, 0);
    tick();
    chk("halt_finished", finished, 1);
    chk("halt_cycle_cnt", cycle_cnt, 3);
    // watchdog
    do_reset(0);
    n = 0;
    while (!timed_out && n < 200) begin
      n++;
      tick();
    end
    chk("tmo_cycles", n, 100);
    chk("tmo_cycle_cnt", cycle_cnt, 100);
    chk("tmo_cpu_rst", cpu_rst, 1);
    chk("tmo_finished", finished, 1);
    repeat (3) tick();
    chk("tmo_frozen", cycle_cnt, 100);
    chk("tmo_sticky", timed_out, 1);
    // halt store on the watchdog cycle wins
    do_reset(0);
    repeat (99) tick();
    chk("race_cnt99", cycle_cnt, 99);
    store(HALT, 8'h2A, 0);
    chk("race_timed_out", timed_out, 0);
    chk("race_exit_code", exit_code, 8'h2A);
    chk("race_finished", finished, 1);
    chk("race_cycle_cnt", cycle_cnt, 100);
    repeat (2) tick();
    chk("race_timed_out_later", timed_out, 0);
    // reset mid-RUN discards FIFO contents and restarts the hold
    store(OUT, 8'h11, 0);
    do_reset(0);
    store(OUT, 8'hE1, 1);
    store(OUT, 8'hE2, 1);
    do_reset(0);
    chk("midrun_fifo_cleared", out_valid, 0);
    repeat (3) tick();
    chk("final_queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
